// File: rtl/vga_fb_reader_if.sv
// Frame-buffer read port: the display reader drives address/strobe, memory returns the pixel.
interface vga_fb_reader_if;
  logic [18:0] rd_addr;
  logic        rd_en;
  logic [3:0]  rd_data;

  modport master (output rd_addr, output rd_en, input rd_data);
  modport slave  (input rd_addr, input rd_en, output rd_data);
endinterface

// File: rtl/vga_fb_reader.sv
// VGA 640x480@60 scan-out from the grayscale frame buffer; sync/blank are delayed
// to line up with the frame-buffer read latency.
module vga_fb_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int RD_LAT   = 1
) (
  input  logic             clk25,
  input  logic             rst_n,
  input  logic             en,
  vga_fb_reader_if.master  fb,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic             frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic vld;
    logic hs;
    logic vs;
    logic first;
  } qual_t;

  localparam qual_t QUAL_IDLE = '{vld: 1'b0, hs: 1'b1, vs: 1'b1, first: 1'b0};

  state_t      state_q, state_d;
  logic [9:0]  h_cnt, v_cnt;
  logic [18:0] rd_addr_q;
  logic        run, h_last, v_last, frame_end, active;
  qual_t       q0, q_out;
  qual_t [RD_LAT-1:0] q_dly;

  assign run       = (state_q == RUN);
  assign h_last    = (h_cnt == H_LAST);
  assign v_last    = (v_cnt == V_LAST);
  assign frame_end = run && h_last && v_last;
  assign active    = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);

  assign q0 = '{vld:   active,
                hs:    !(run && (h_cnt >= HS_BEG) && (h_cnt < HS_END)),
                vs:    !(run && (v_cnt >= VS_BEG) && (v_cnt < VS_END)),
                first: run && (h_cnt == 10'd0) && (v_cnt == 10'd0)};

  assign fb.rd_en   = active;
  assign fb.rd_addr = rd_addr_q;

  // en only matters at frame end so a mid-frame drop still finishes the frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (frame_end && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run || frame_end) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Running linear address: holds through blanking, so it already points at the next line.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n)                rd_addr_q <= '0;
    else if (!run || frame_end) rd_addr_q <= '0;
    else if (active)           rd_addr_q <= rd_addr_q + 19'd1;
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      q_dly <= {RD_LAT{QUAL_IDLE}};
    end else begin
      q_dly[0] <= q0;
      for (int i = 1; i < RD_LAT; i++) q_dly[i] <= q_dly[i-1];
    end
  end

  assign q_out = q_dly[RD_LAT-1];

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= q_out.vld ? fb.rd_data : 4'h0;
      vga_g       <= q_out.vld ? fb.rd_data : 4'h0;
      vga_b       <= q_out.vld ? fb.rd_data : 4'h0;
      vga_hsync   <= q_out.hs;
      vga_vsync   <= q_out.vs;
      frame_start <= q_out.first;
    end
  end
endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench on a shrunken raster (25x11 totals, 16x6 visible), RD_LAT 1 and 3 side by side.
module tb_vga_fb_reader;
  logic clk25 = 1'b0;
  logic rst_n, en;
  always #5 clk25 = ~clk25;

  vga_fb_reader_if if1();
  vga_fb_reader_if if3();

  logic [3:0] r1, g1, b1, r3, g3, b3;
  logic hs1, vs1, fs1, hs3, vs3, fs3;

  vga_fb_reader #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                  .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .RD_LAT(1)) u_lat1 (
    .clk25(clk25), .rst_n(rst_n), .en(en), .fb(if1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .vga_hsync(hs1), .vga_vsync(vs1), .frame_start(fs1));

  vga_fb_reader #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                  .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .RD_LAT(3)) u_lat3 (
    .clk25(clk25), .rst_n(rst_n), .en(en), .fb(if3),
    .vga_r(r3), .vga_g(g3), .vga_b(b3),
    .vga_hsync(hs3), .vga_vsync(vs3), .frame_start(fs3));

  // Memory model returns addr[3:0] after the configured latency.
  logic [3:0] m1;
  logic [3:0] m3 [3];
  always_ff @(posedge clk25) begin
    m1    <= if1.rd_addr[3:0];
    m3[0] <= if3.rd_addr[3:0];
    m3[1] <= m3[0];
    m3[2] <= m3[1];
  end
  assign if1.rd_data = m1;
  assign if3.rd_data = m3[2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk25);
    @(negedge clk25);
  endtask

  int fs1_first = -1, fs3_first = -1, hs1_first = -1, vs1_first = -1;
  int fs1_cnt = 0, hs_low0 = 0, vs0_cnt = 0, vs1_cnt = 0;
  int ren0 = 0, ren1 = 0, ren_idle = 0, idle_bad = 0, idle_bad2 = 0, ren_rst = 0;

  task automatic sample(input int k);
    if (fs1 && fs1_first < 0) fs1_first = k;
    if (fs3 && fs3_first < 0) fs3_first = k;
    if (fs1) fs1_cnt++;
    if (!hs1 && hs1_first < 0) hs1_first = k;
    if (!hs1 && k < 25) hs_low0++;
    if (!vs1 && vs1_first < 0) vs1_first = k;
    if (!vs1) begin
      if (k < 275) vs0_cnt++;
      else if (k < 560) vs1_cnt++;
    end
    if (if1.rd_en) begin
      if (k < 275) ren0++;
      else if (k < 550) ren1++;
      else ren_idle++;
    end
    if (k >= 554 && (r3 != 0 || !hs3 || !vs3 || fs3)) idle_bad2++;
    case (k)
      0:   begin chk("addr_k0", int'(if1.rd_addr), 0); chk("ren_k0", int'(if1.rd_en), 1); end
      5:   chk("addr_k5", int'(if1.rd_addr), 5);
      7:   begin chk("r1_k7", int'(r1), 5); chk("g1_k7", int'(g1), 5); chk("b1_k7", int'(b1), 5); end
      9:   chk("r3_k9", int'(r3), 5);
      16:  chk("addr_blank0", int'(if1.rd_addr), 16);
      17:  chk("r1_lastpix", int'(r1), 15);
      18:  chk("r1_noleak", int'(r1), 0);
      19:  chk("r3_lastpix", int'(r3), 15);
      20:  chk("r3_noleak", int'(r3), 0);
      24:  chk("addr_hold", int'(if1.rd_addr), 16);
      30:  begin chk("addr_l1h5", int'(if1.rd_addr), 21); chk("r1_l1h3", int'(r1), 3); end
      140: begin chk("addr_last", int'(if1.rd_addr), 95); chk("addr3_last", int'(if3.rd_addr), 95); end
      150: chk("addr_vblank", int'(if1.rd_addr), 96);
      274: chk("addr_end", int'(if1.rd_addr), 96);
      275: chk("addr_wrap", int'(if1.rd_addr), 0);
      549: begin chk("addr_f1end", int'(if1.rd_addr), 96); chk("ren_f1end", int'(if1.rd_en), 0); end
      550: chk("addr_idle", int'(if1.rd_addr), 0);
      default: ;
    endcase
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    @(negedge clk25);
    @(negedge clk25);
    chk("rst_r", int'(r1), 0);
    chk("rst_hs", int'(hs1), 1);
    chk("rst_vs", int'(vs3), 1);
    chk("rst_fs", int'(fs1), 0);
    chk("rst_ren", int'(if1.rd_en), 0);
    chk("rst_addr", int'(if3.rd_addr), 0);

    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step;
      if (if1.rd_en || if3.rd_en || r1 != 0 || r3 != 0 || !hs1 || !vs1 || !hs3 || !vs3 || fs1 || fs3)
        idle_bad++;
    end
    chk("idle_quiet", idle_bad, 0);

    en = 1'b1;
    step;
    for (int k = 0; k < 620; k++) begin
      sample(k);
      if (k == 325) en = 1'b0;
      step;
    end
    chk("fs1_first", fs1_first, 2);
    chk("fs3_first", fs3_first, 4);
    chk("fs1_count", fs1_cnt, 2);
    chk("hs_first", hs1_first, 20);
    chk("hs_width", hs_low0, 4);
    chk("vs_first", vs1_first, 177);
    chk("vs_low_f0", vs0_cnt, 50);
    chk("vs_low_f1", vs1_cnt, 50);
    chk("ren_f0", ren0, 96);
    chk("ren_f1", ren1, 96);
    chk("ren_idle", ren_idle, 0);
    chk("flush_blank", idle_bad2, 0);

    en = 1'b1;
    step;
    for (int k = 0; k < 85; k++) begin
      if (k == 0) begin
        chk("re_addr0", int'(if1.rd_addr), 0);
        chk("re_ren0", int'(if1.rd_en), 1);
      end
      if (k == 2) chk("re_fs", int'(fs1), 1);
      step;
    end
    chk("pre_rst_r1", int'(r1), 8);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_r1", int'(r1), 0);
    chk("arst_r3", int'(r3), 0);
    chk("arst_ren", int'(if1.rd_en), 0);
    chk("arst_addr", int'(if1.rd_addr), 0);
    chk("arst_hs", int'(hs1), 1);
    @(negedge clk25);
    @(negedge clk25);
    rst_n = 1'b1;
    step;
    for (int k = 0; k < 275; k++) begin
      if (if1.rd_en) ren_rst++;
      if (k == 2)   chk("post_fs", int'(fs1), 1);
      if (k == 7)   chk("post_r1", int'(r1), 5);
      if (k == 140) chk("post_addr_last", int'(if1.rd_addr), 95);
      if (k == 274) chk("post_addr_end", int'(if1.rd_addr), 96);
      step;
    end
    chk("post_ren", ren_rst, 96);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
